// File: rtl/vcd_change_decoder.sv
// Byte-serial decoder for simplified VCD text: "#<time>" lines advance the scaled
// current time, "<v><id>" lines emit timestamped change events through a ready/valid port.
module vcd_change_decoder #(
  parameter int TIME_W  = 64,
  parameter int TS_MULT = 1000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [TIME_W-1:0] evt_time,
  output logic [1:0]        evt_val,
  output logic [7:0]        evt_id,
  output logic [TIME_W-1:0] cur_time,
  output logic              err_fmt,
  output logic              err_ovf,
  output logic              err_order
);

  localparam logic [2:0] S_LINE = 3'd0;
  localparam logic [2:0] S_TIME = 3'd1;
  localparam logic [2:0] S_VID  = 3'd2;
  localparam logic [2:0] S_VEOL = 3'd3;
  localparam logic [2:0] S_SKIP = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [TIME_W-1:0] acc_q, acc_d;
  logic              have_dig_q, have_dig_d;
  logic [1:0]        val_q, val_d;
  logic [7:0]        id_q, id_d;
  logic [TIME_W-1:0] cur_time_q, cur_time_d;
  logic              err_fmt_q, err_fmt_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_order_q, err_order_d;
  logic              evt_valid_q;
  logic [TIME_W-1:0] evt_time_q;
  logic [1:0]        evt_val_q;
  logic [7:0]        evt_id_q;
  logic              load_evt;

  logic              fire, is_nl, is_cr, is_dig, is_val, is_id;
  logic [1:0]        val_code;
  logic [TIME_W+3:0] acc_ext, acc_mul;
  logic              acc_ovf;
  logic [TIME_W+31:0] scaled;
  logic              scl_ovf;
  logic [TIME_W-1:0] commit_t;

  assign in_ready = !(evt_valid_q && !evt_ready);
  assign fire     = in_valid && in_ready;
  assign is_nl    = (in_byte == 8'h0A);
  assign is_cr    = (in_byte == 8'h0D);
  assign is_dig   = (in_byte >= 8'h30) && (in_byte <= 8'h39);
  assign is_id    = (in_byte >= 8'h21) && (in_byte <= 8'h7E);

  always_comb begin
    is_val   = 1'b1;
    val_code = 2'd0;
    case (in_byte)
      "0":      val_code = 2'd0;
      "1":      val_code = 2'd1;
      "x", "X": val_code = 2'd2;
      "z", "Z": val_code = 2'd3;
      default:  is_val = 1'b0;
    endcase
  end

  // acc*10+d computed 4 bits wider so any carry past TIME_W flags saturation
  assign acc_ext  = {4'b0, acc_q};
  assign acc_mul  = (acc_ext << 3) + (acc_ext << 1) + {{TIME_W{1'b0}}, in_byte[3:0]};
  assign acc_ovf  = |acc_mul[TIME_W+3:TIME_W];
  assign scaled   = {32'b0, acc_q} * {{TIME_W{1'b0}}, 32'(TS_MULT)};
  assign scl_ovf  = |scaled[TIME_W+31:TIME_W];
  assign commit_t = scl_ovf ? {TIME_W{1'b1}} : scaled[TIME_W-1:0];

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    have_dig_d  = have_dig_q;
    val_d       = val_q;
    id_d        = id_q;
    cur_time_d  = cur_time_q;
    err_fmt_d   = err_fmt_q;
    err_ovf_d   = err_ovf_q;
    err_order_d = err_order_q;
    load_evt    = 1'b0;
    if (fire && !is_cr) begin
      case (state_q)
        S_LINE: begin
          if (in_byte == "#") begin
            state_d    = S_TIME;
            acc_d      = '0;
            have_dig_d = 1'b0;
          end else if (is_val) begin
            state_d = S_VID;
            val_d   = val_code;
          end else if (!is_nl) begin
            state_d   = S_SKIP;
            err_fmt_d = 1'b1;
          end
        end
        S_TIME: begin
          if (is_dig) begin
            acc_d      = acc_ovf ? {TIME_W{1'b1}} : acc_mul[TIME_W-1:0];
            have_dig_d = 1'b1;
            if (acc_ovf) err_ovf_d = 1'b1;
          end else if (is_nl) begin
            state_d = S_LINE;
            if (!have_dig_q) begin
              err_fmt_d = 1'b1;
            end else begin
              if (scl_ovf) err_ovf_d = 1'b1;
              if (commit_t < cur_time_q) err_order_d = 1'b1;
              else                       cur_time_d  = commit_t;
            end
          end else begin
            state_d   = S_SKIP;
            err_fmt_d = 1'b1;
          end
        end
        S_VID: begin
          if (is_id) begin
            state_d = S_VEOL;
            id_d    = in_byte;
          end else begin
            // a newline here already ends the bad line; skipping would eat the next one
            state_d   = is_nl ? S_LINE : S_SKIP;
            err_fmt_d = 1'b1;
          end
        end
        S_VEOL: begin
          if (is_nl) begin
            state_d  = S_LINE;
            load_evt = 1'b1;
          end else begin
            state_d   = S_SKIP;
            err_fmt_d = 1'b1;
          end
        end
        S_SKIP:  if (is_nl) state_d = S_LINE;
        default: state_d = S_LINE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_LINE;
      acc_q       <= '0;
      have_dig_q  <= 1'b0;
      val_q       <= 2'd0;
      id_q        <= 8'd0;
      cur_time_q  <= '0;
      err_fmt_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_order_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      have_dig_q  <= have_dig_d;
      val_q       <= val_d;
      id_q        <= id_d;
      cur_time_q  <= cur_time_d;
      err_fmt_q   <= err_fmt_d;
      err_ovf_q   <= err_ovf_d;
      err_order_q <= err_order_d;
    end
  end

  // load only happens on an accepted byte, so a held event is never overwritten
  always_ff @(posedge clock) begin
    if (reset) begin
      evt_valid_q <= 1'b0;
      evt_time_q  <= '0;
      evt_val_q   <= 2'd0;
      evt_id_q    <= 8'd0;
    end else if (load_evt) begin
      evt_valid_q <= 1'b1;
      evt_time_q  <= cur_time_q;
      evt_val_q   <= val_q;
      evt_id_q    <= id_q;
    end else if (evt_ready) begin
      evt_valid_q <= 1'b0;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_time  = evt_time_q;
  assign evt_val   = evt_val_q;
  assign evt_id    = evt_id_q;
  assign cur_time  = cur_time_q;
  assign err_fmt   = err_fmt_q;
  assign err_ovf   = err_ovf_q;
  assign err_order = err_order_q;

endmodule

// File: tb/tb_vcd_change_decoder.sv
// Directed and randomized checks of vcd_change_decoder against a line-level reference model.
module tb_vcd_change_decoder;

  typedef struct {
    logic [63:0] t;
    logic [1:0]  v;
    logic [7:0]  id;
  } ev_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset = 1'b1;
  logic       sel = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic       evt_ready = 1'b0;

  logic        a_in_ready, a_evt_valid, a_fmt, a_ovf, a_order;
  logic [63:0] a_evt_time, a_cur_time;
  logic [1:0]  a_evt_val;
  logic [7:0]  a_evt_id;
  logic        b_in_ready, b_evt_valid, b_fmt, b_ovf, b_order;
  logic [15:0] b_evt_time, b_cur_time;
  logic [1:0]  b_evt_val;
  logic [7:0]  b_evt_id;

  vcd_change_decoder #(.TIME_W(64), .TS_MULT(1000)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid && !sel), .in_byte(in_byte),
    .in_ready(a_in_ready), .evt_valid(a_evt_valid), .evt_ready(evt_ready),
    .evt_time(a_evt_time), .evt_val(a_evt_val), .evt_id(a_evt_id),
    .cur_time(a_cur_time), .err_fmt(a_fmt), .err_ovf(a_ovf), .err_order(a_order));

  vcd_change_decoder #(.TIME_W(16), .TS_MULT(1000)) dut16 (
    .clock(clock), .reset(reset), .in_valid(in_valid && sel), .in_byte(in_byte),
    .in_ready(b_in_ready), .evt_valid(b_evt_valid), .evt_ready(evt_ready),
    .evt_time(b_evt_time), .evt_val(b_evt_val), .evt_id(b_evt_id),
    .cur_time(b_cur_time), .err_fmt(b_fmt), .err_ovf(b_ovf), .err_order(b_order));

  wire        s_in_ready  = sel ? b_in_ready  : a_in_ready;
  wire        s_evt_valid = sel ? b_evt_valid : a_evt_valid;
  wire [63:0] s_evt_time  = sel ? {48'b0, b_evt_time} : a_evt_time;
  wire [1:0]  s_evt_val   = sel ? b_evt_val : a_evt_val;
  wire [7:0]  s_evt_id    = sel ? b_evt_id  : a_evt_id;
  wire [63:0] s_cur_time  = sel ? {48'b0, b_cur_time} : a_cur_time;
  wire [2:0]  s_flags     = sel ? {b_fmt, b_ovf, b_order} : {a_fmt, a_ovf, a_order};

  int  errs = 0;
  int  checks = 0;
  int  ready_mode = 1;  // 0: hold low, 1: always high, 2: random
  bit  hold_prev = 1'b0;
  ev_t hold_ev;
  ev_t got_q[$];
  ev_t exp_q[$];

  // reference model state (64-bit instance)
  localparam logic [63:0] MAX64 = 64'hFFFF_FFFF_FFFF_FFFF;
  logic [63:0] m_cur;
  bit          m_fmt, m_ovf, m_order;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ev(input string tag, input int idx, input logic [63:0] t,
                        input logic [1:0] v, input logic [7:0] id);
    ev_t e;
    e.t = 'x; e.v = 'x; e.id = 'x;
    if (idx < got_q.size()) e = got_q[idx];
    chk(tag, {6'b0, e.t, e.v, e.id}, {6'b0, t, v, id});
  endtask

  task automatic step(input bit v, input logic [7:0] b, output bit took);
    ev_t cur;
    @(negedge clock);
    case (ready_mode)
      0:       evt_ready = 1'b0;
      1:       evt_ready = 1'b1;
      default: evt_ready = ($urandom_range(0, 2) != 0);
    endcase
    in_valid = v;
    in_byte  = b;
    #1;
    cur.t = s_evt_time; cur.v = s_evt_val; cur.id = s_evt_id;
    if (hold_prev)
      chk("evt_hold", {5'b0, s_evt_valid, cur.t, cur.v, cur.id},
          {5'b0, 1'b1, hold_ev.t, hold_ev.v, hold_ev.id});
    chk("in_ready_rule", {79'b0, s_in_ready}, {79'b0, !(s_evt_valid && !evt_ready)});
    hold_prev = s_evt_valid && !evt_ready;
    hold_ev   = cur;
    if (s_evt_valid && evt_ready) got_q.push_back(cur);
    took = v && s_in_ready;
  endtask

  task automatic idle(input int n);
    bit took;
    repeat (n) step(1'b0, 8'h00, took);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit took = 1'b0;
    int n = 0;
    if ($urandom_range(0, 4) == 0) idle(1);
    while (!took && n < 300) begin
      step(1'b1, b, took);
      n++;
    end
    if (!took) begin
      checks++;
      errs++;
      $error("FAIL send_timeout: byte %0h not accepted within %0d cycles", b, n);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b0; evt_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    hold_prev = 1'b0;
    got_q.delete();
  endtask

  // Line-level reference: strip CRs, then classify the whole line.
  task automatic model_line(input string s);
    logic [7:0] q[$];
    logic [63:0] acc, t, d;
    bit ok, any;
    ev_t e;
    for (int i = 0; i < s.len(); i++) if (s[i] != 8'h0D) q.push_back(s[i]);
    if (q.size() == 0) return;
    if (q[0] == "#") begin
      acc = 0; ok = 1'b1; any = 1'b0;
      for (int i = 1; i < q.size(); i++) begin
        if (q[i] >= "0" && q[i] <= "9") begin
          d = 64'(q[i] - 8'h30);
          if (acc > (MAX64 - d) / 10) begin acc = MAX64; m_ovf = 1'b1; end
          else acc = acc * 10 + d;
          any = 1'b1;
        end else begin
          ok = 1'b0;
          break;
        end
      end
      if (!ok || !any) m_fmt = 1'b1;
      else begin
        if (acc != 0 && acc > MAX64 / 1000) begin t = MAX64; m_ovf = 1'b1; end
        else t = acc * 1000;
        if (t < m_cur) m_order = 1'b1;
        else m_cur = t;
      end
    end else if (q[0] inside {"0", "1", "x", "X", "z", "Z"}) begin
      if (q.size() == 2 && q[1] >= 8'h21 && q[1] <= 8'h7E) begin
        e.t = m_cur;
        e.v = (q[0] == "0") ? 2'd0 : (q[0] == "1") ? 2'd1 :
              (q[0] == "x" || q[0] == "X") ? 2'd2 : 2'd3;
        e.id = q[1];
        exp_q.push_back(e);
      end else m_fmt = 1'b1;
    end else m_fmt = 1'b1;
  endtask

  initial begin
    bit took;
    string line, vs;
    string bad[8];
    logic [63:0] mt, tv;
    int r, k;
    bad = '{"q!", "1", "#", "#1a", "1!!", "1 ", "", "#4#"};
    vs = "01xzXZ";

    // reset state and first event with latency
    sel = 1'b0;
    do_reset();
    #1;
    chk("rst_in_ready", {79'b0, a_in_ready}, 80'd1);
    chk("rst_evt", {5'b0, a_evt_valid, a_evt_time, a_evt_val, a_evt_id}, 80'd0);
    chk("rst_cur_time", {16'b0, a_cur_time}, 80'd0);
    chk("rst_flags", {77'b0, a_fmt, a_ovf, a_order}, 80'd0);
    ready_mode = 1;
    send_str("#5\n1!\n");
    chk("t1_no_early_evt", 80'(got_q.size()), 80'd0);
    idle(1);
    chk("t1_evt_count", 80'(got_q.size()), 80'd1);
    chk_ev("t1_evt", 0, 64'd5000, 2'd1, 8'h21);
    chk("t1_flags", {77'b0, a_fmt, a_ovf, a_order}, 80'd0);

    // backpressure: event held, in_ready low, then drains in order
    do_reset();
    ready_mode = 0;
    send_str("#3\n0a\n");
    idle(1);
    chk("t2_held", {5'b0, a_evt_valid, a_evt_time, a_evt_val, a_evt_id},
        {5'b0, 1'b1, 64'd3000, 2'd0, 8'h61});
    for (int i = 0; i < 10; i++) begin
      step(1'b1, "z", took);
      chk("t2_stall", {79'b0, took}, 80'd0);
    end
    ready_mode = 2;
    send_str("z\"\n");
    ready_mode = 1;
    idle(5);
    chk("t2_evt_count", 80'(got_q.size()), 80'd2);
    chk_ev("t2_evt0", 0, 64'd3000, 2'd0, 8'h61);
    chk_ev("t2_evt1", 1, 64'd3000, 2'd3, 8'h22);

    // decreasing timestamp
    do_reset();
    send_str("#20\n#10\nx#\n");
    idle(3);
    chk("t3_flags", {77'b0, a_fmt, a_ovf, a_order}, 80'b001);
    chk("t3_cur_time", {16'b0, a_cur_time}, 80'd20000);
    chk("t3_evt_count", 80'(got_q.size()), 80'd1);
    chk_ev("t3_evt", 0, 64'd20000, 2'd2, 8'h23);

    // 16-bit instance saturation
    sel = 1'b1;
    do_reset();
    send_str("#65\n");
    idle(2);
    chk("t4_below_sat", {16'b0, s_cur_time}, 80'd65000);
    chk("t4_below_flags", {77'b0, s_flags}, 80'd0);
    send_str("#70\n");
    idle(2);
    chk("t4_scale_sat", {16'b0, s_cur_time}, 80'd65535);
    chk("t4_scale_flags", {77'b0, s_flags}, 80'b010);
    do_reset();
    send_str("#99999\n");
    idle(2);
    chk("t4_acc_sat", {16'b0, s_cur_time}, 80'd65535);
    chk("t4_acc_flags", {77'b0, s_flags}, 80'b010);
    sel = 1'b0;

    // malformed lines, then recovery
    do_reset();
    send_str("#5\n");
    send_str("#\nq!\n1\n");
    idle(3);
    chk("t5_flags", {77'b0, a_fmt, a_ovf, a_order}, 80'b100);
    chk("t5_no_evt", 80'(got_q.size()), 80'd0);
    chk("t5_cur_time", {16'b0, a_cur_time}, 80'd5000);
    send_str("1!\n");
    idle(2);
    chk("t5_recover_count", 80'(got_q.size()), 80'd1);
    chk_ev("t5_recover", 0, 64'd5000, 2'd1, 8'h21);

    // reset mid-line
    do_reset();
    send_str("#7\nq\n#12");
    do_reset();
    idle(1);
    chk("t6_cur_time", {16'b0, a_cur_time}, 80'd0);
    chk("t6_flags", {77'b0, a_fmt, a_ovf, a_order}, 80'd0);
    send_str("1$\n");
    idle(2);
    chk_ev("t6_evt", 0, 64'd0, 2'd1, 8'h24);

    // randomized stream against the line-level model
    do_reset();
    exp_q.delete();
    m_cur = 0; m_fmt = 0; m_ovf = 0; m_order = 0; mt = 0;
    ready_mode = 2;
    for (int n = 0; n < 220; n++) begin
      r = $urandom_range(0, 99);
      if (r < 22) begin
        k = $urandom_range(0, 99);
        if (n > 180 && k < 8)       line = "#99999999999999999999";
        else if (n > 180 && k < 16) line = "#18446744073709552";
        else begin
          if (k < 25 && mt > 0) tv = mt - 64'($urandom_range(1, 5));
          else tv = mt + 64'($urandom_range(0, 40));
          if (tv > mt) mt = tv;
          line = $sformatf("#%0d", tv);
        end
      end else if (r < 85) begin
        line = $sformatf("%c%c", vs[$urandom_range(0, 5)], 8'($urandom_range(33, 126)));
      end else begin
        line = bad[$urandom_range(0, 7)];
      end
      if ($urandom_range(0, 9) == 0) line = {line, "\015"};
      model_line(line);
      send_str({line, "\n"});
    end
    ready_mode = 1;
    idle(10);
    chk("rnd_evt_count", 80'(got_q.size()), 80'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk_ev($sformatf("rnd_evt%0d", i), i, exp_q[i].t, exp_q[i].v, exp_q[i].id);
    chk("rnd_cur_time", {16'b0, a_cur_time}, {16'b0, m_cur});
    chk("rnd_flags", {77'b0, a_fmt, a_ovf, a_order}, {77'b0, m_fmt, m_ovf, m_order});

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
